// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: one outstanding bus access, lane steering, bus timeout
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   localparam int CLOG = $clog2(TIMEOUT + 1);
   localparam int CW = (CLOG > 8) ? CLOG : 8;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state_q, state_d;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_inc;
   logic          flt_q;
   logic [31:0]   data_q;
   logic          we_q;
   logic [2:0]    type_q;
   logic [1:0]    ofs_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    be_q;

   logic          access;
   logic          legal;
   logic          aligned;
   logic          accept;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   load_val;

   always_comb begin
      access = MemRead | MemWrite;
      legal  = 1'b0;
      if (MemRead && !MemWrite)
         legal = (Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      else if (MemWrite && !MemRead)
         legal = (Funct3 inside {3'b000, 3'b001, 3'b010});
      case (Funct3[1:0])
         2'b01:   aligned = ~ALUResult[0];
         2'b10:   aligned = (ALUResult[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      accept = access & legal & aligned;
   end

   // Store data is replicated on every lane so the bus can pick any byte enable pattern.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = 32'h0;
      if (MemWrite) begin
         case (Funct3[1:0])
            2'b00: begin
               be_d    = 4'b0001 << ALUResult[1:0];
               wdata_d = {4{WriteData[7:0]}};
            end
            2'b01: begin
               be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{WriteData[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = WriteData;
            end
         endcase
      end
   end

   always_comb begin
      case (ofs_q)
         2'b00:   lane_b = mem_rdata[7:0];
         2'b01:   lane_b = mem_rdata[15:8];
         2'b10:   lane_b = mem_rdata[23:16];
         default: lane_b = mem_rdata[31:24];
      endcase
      lane_h = ofs_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (type_q)
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_val = {24'h0, lane_b};
         3'b101:  load_val = {16'h0, lane_h};
         default: load_val = mem_rdata;
      endcase
   end

   assign cnt_inc = cnt_q + CW'(1);

   // The IDLE outputs are combinational from the core, so they are gated by reset as well.
   always_comb begin
      state_d  = state_q;
      Stall    = 1'b0;
      Fault    = 1'b0;
      ReadData = 32'h0;
      mem_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (reset && access) begin
               if (accept) begin
                  Stall   = 1'b1;
                  state_d = BUSY;
               end else begin
                  Fault = 1'b1;
               end
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            Stall   = 1'b1;
            if (mem_ready || cnt_inc == LIMIT)
               state_d = DONE;
         end
         DONE: begin
            ReadData = data_q;
            Fault    = flt_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_we    = we_q & mem_req;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flt_q   <= 1'b0;
         data_q  <= 32'h0;
         we_q    <= 1'b0;
         type_q  <= 3'b000;
         ofs_q   <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'b0000;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q  <= {ALUResult[31:2], 2'b00};
                  be_q    <= be_d;
                  wdata_q <= wdata_d;
                  we_q    <= MemWrite;
                  type_q  <= Funct3;
                  ofs_q   <= ALUResult[1:0];
                  cnt_q   <= '0;
                  flt_q   <= 1'b0;
                  data_q  <= 32'h0;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  data_q <= we_q ? 32'h0 : load_val;
                  cnt_q  <= '0;
                  flt_q  <= 1'b0;
               end else if (cnt_inc == LIMIT) begin
                  data_q <= 32'h0;
                  cnt_q  <= '0;
                  flt_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a behavioural access model
module tb_load_store_unit;
   logic        clk, reset, MemRead, MemWrite, mem_ready;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData, mem_rdata, ReadData, mem_addr, mem_wdata;
   logic        Stall, Fault, mem_req, mem_we;
   logic [3:0]  mem_be;

   int tests_run = 0;
   int tests_failed = 0;

   logic        o_fault1, o_stall1, o_req1;
   logic [31:0] o_rd1;
   int          o_occ, o_busy, o_stall_cnt;
   logic [31:0] o_addr, o_wdata, o_done_rd, o_rd_after;
   logic [3:0]  o_be;
   logic        o_we, o_unstable, o_stray_fault, o_done_seen, o_done_fault, o_done_stall;
   logic        o_req_after, o_fault_after, o_stall_after;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
      .Fault(Fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: what a single access should produce, from the ISA rules alone.
   function automatic void model(input bit mr, input bit mw, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                 output bit ok, output logic [3:0] be, output logic [31:0] wdat,
                                 output logic [31:0] res);
      int size, ofs;
      logic [31:0] v;
      size = 1 << (f3 % 4);
      ofs  = int'(a[1:0]);
      if (mr && mw)   ok = 1'b0;
      else if (mr)    ok = (f3 != 3 && f3 != 6 && f3 != 7);
      else            ok = (f3 <= 2);
      if (ok && (ofs % size) != 0) ok = 1'b0;
      be = 4'hF; wdat = wd; res = 32'h0;
      if (mw) begin
         if (size == 1) begin be = 4'(1 << ofs); wdat = (wd & 32'hFF) * 32'h01010101; end
         else if (size == 2) begin be = 4'(3 << ofs); wdat = (wd & 32'hFFFF) * 32'h00010001; end
      end else begin
         v = rd >> (8 * ofs);
         if (size == 1) begin
            res = v & 32'hFF;
            if (f3 < 4 && res >= 128) res = res + 32'hFFFFFF00;
         end else if (size == 2) begin
            res = v & 32'hFFFF;
            if (f3 < 4 && res >= 32768) res = res + 32'hFFFF0000;
         end else begin
            res = rd;
         end
      end
   endfunction

   // Presents one instruction, answers the bus after `delay` BUSY cycles, records what it saw.
   task automatic do_access(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int delay);
      o_busy = 0; o_unstable = 0; o_stray_fault = 0; o_done_seen = 0;
      o_done_rd = 32'h0; o_done_fault = 0; o_done_stall = 0;
      o_addr = 32'h0; o_be = 4'h0; o_wdata = 32'h0; o_we = 0;
      @(negedge clk);
      MemRead = mr; MemWrite = mw; Funct3 = f3; ALUResult = a; WriteData = wd;
      mem_rdata = rd; mem_ready = 1'b0;
      #1;
      o_fault1 = Fault; o_stall1 = Stall; o_req1 = mem_req; o_rd1 = ReadData;
      o_occ = 1; o_stall_cnt = int'(Stall);
      if (Stall) begin
         for (int c = 0; c < 32 && !o_done_seen; c++) begin
            @(negedge clk);
            mem_ready = (o_busy == delay);
            #1;
            o_occ++;
            o_stall_cnt += int'(Stall);
            if (mem_req) begin
               if (o_busy == 0) begin
                  o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
               end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata || mem_we !== o_we) begin
                  o_unstable = 1;
               end
               if (Fault) o_stray_fault = 1;
               o_busy++;
            end else begin
               o_done_seen = 1; o_done_rd = ReadData; o_done_fault = Fault; o_done_stall = Stall;
            end
         end
      end
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
      #1;
      o_req_after = mem_req; o_fault_after = Fault; o_stall_after = Stall; o_rd_after = ReadData;
   endtask

   task automatic test_reset();
      reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h100;
      WriteData = 32'hFFFFFFFF; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      #1;
      tests_run++; if ({mem_req, mem_we, Stall, Fault} !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctrl: req/we/stall/fault=%b expected 0000", {mem_req, mem_we, Stall, Fault}); end
      tests_run++; if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_bus: be=%h addr=%h wdata=%h expected zeros", mem_be, mem_addr, mem_wdata); end
      tests_run++; if (ReadData !== 32'h0) begin tests_failed++; $display("FAIL reset_readdata: got %h expected 0", ReadData); end
      MemRead = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_lw_basic();
      do_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      tests_run++; if (o_stall_cnt !== 2) begin tests_failed++; $display("FAIL lw_stall_cycles: got %0d expected 2", o_stall_cnt); end
      tests_run++; if (o_occ !== 3) begin tests_failed++; $display("FAIL lw_occupancy: got %0d expected 3", o_occ); end
      tests_run++; if (o_done_rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL lw_readdata: got %h expected deadbeef", o_done_rd); end
      tests_run++; if (o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin tests_failed++; $display("FAIL lw_bus: addr=%h be=%b we=%b expected 100/1111/0", o_addr, o_be, o_we); end
      tests_run++; if (o_req_after !== 1'b0 || o_rd_after !== 32'h0) begin tests_failed++; $display("FAIL lw_after: req=%b rd=%h expected 0/0", o_req_after, o_rd_after); end
   endtask

   task automatic test_lb_lbu();
      do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
      tests_run++; if (o_done_rd !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL lb_sign: got %h expected ffffff80", o_done_rd); end
      do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
      tests_run++; if (o_done_rd !== 32'h00000080) begin tests_failed++; $display("FAIL lbu_zero: got %h expected 00000080", o_done_rd); end
      tests_run++; if (o_occ !== 4) begin tests_failed++; $display("FAIL lbu_occupancy: got %0d expected 4", o_occ); end
   endtask

   task automatic test_sh();
      do_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h55555555, 0);
      tests_run++; if (o_be !== 4'b1100) begin tests_failed++; $display("FAIL sh_be: got %b expected 1100", o_be); end
      tests_run++; if (o_wdata !== 32'hABCDABCD) begin tests_failed++; $display("FAIL sh_wdata: got %h expected abcdabcd", o_wdata); end
      tests_run++; if (o_we !== 1'b1 || o_addr !== 32'h200) begin tests_failed++; $display("FAIL sh_we_addr: we=%b addr=%h expected 1/200", o_we, o_addr); end
      tests_run++; if (o_done_rd !== 32'h0) begin tests_failed++; $display("FAIL sh_readdata: got %h expected 0", o_done_rd); end
   endtask

   task automatic test_illegal();
      bit          mr_t [6] = '{1, 1, 1, 0, 0, 1};
      bit          mw_t [6] = '{0, 1, 0, 1, 1, 0};
      logic [2:0]  f3_t [6] = '{3'b010, 3'b010, 3'b011, 3'b100, 3'b001, 3'b101};
      logic [31:0] a_t  [6] = '{32'h101, 32'h10, 32'h10, 32'h10, 32'h11, 32'h13};
      for (int i = 0; i < 6; i++) begin
         do_access(mr_t[i], mw_t[i], f3_t[i], a_t[i], 32'h12345678, 32'h87654321, 0);
         tests_run++; if ({o_fault1, o_stall1, o_req1} !== 3'b100 || o_rd1 !== 32'h0) begin tests_failed++; $display("FAIL illegal_%0d: fault/stall/req=%b rd=%h expected 100/0", i, {o_fault1, o_stall1, o_req1}, o_rd1); end
         tests_run++; if (o_fault_after !== 1'b0 || o_req_after !== 1'b0) begin tests_failed++; $display("FAIL illegal_%0d_pulse: fault=%b req=%b next cycle expected 0/0", i, o_fault_after, o_req_after); end
      end
   endtask

   task automatic test_timeout();
      do_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h12345678, 99);
      tests_run++; if (o_busy !== 4) begin tests_failed++; $display("FAIL timeout_busy: got %0d BUSY cycles expected 4", o_busy); end
      tests_run++; if (o_done_seen !== 1'b1 || o_done_fault !== 1'b1) begin tests_failed++; $display("FAIL timeout_fault: done=%b fault=%b expected 1/1", o_done_seen, o_done_fault); end
      tests_run++; if (o_done_rd !== 32'h0 || o_done_stall !== 1'b0) begin tests_failed++; $display("FAIL timeout_done: rd=%h stall=%b expected 0/0", o_done_rd, o_done_stall); end
      tests_run++; if (o_fault_after !== 1'b0 || o_req_after !== 1'b0) begin tests_failed++; $display("FAIL timeout_after: fault=%b req=%b expected 0/0", o_fault_after, o_req_after); end
   endtask

   task automatic test_reset_mid_busy();
      logic saw;
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h300; mem_ready = 1'b0;
      @(negedge clk);
      #1;
      tests_run++; if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy: req=%b expected 1", mem_req); end
      reset = 1'b0;
      #1;
      tests_run++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin tests_failed++; $display("FAIL midreset_async: req=%b stall=%b expected 0/0", mem_req, Stall); end
      MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (mem_req || Stall) saw = 1'b1;
      end
      tests_run++; if (saw !== 1'b0) begin tests_failed++; $display("FAIL midreset_replay: bus activity after release=%b expected 0", saw); end
      do_access(1, 0, 3'b001, 32'h306, 32'h0, 32'h9ABC0000, 1);
      tests_run++; if (o_done_rd !== 32'hFFFF9ABC || o_occ !== 4) begin tests_failed++; $display("FAIL midreset_next: rd=%h occ=%0d expected ffff9abc/4", o_done_rd, o_occ); end
   endtask

   task automatic test_random();
      bit          mr, mw, ok;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd, exp_wd, exp_rd;
      logic [3:0]  exp_be;
      int          dly, sel;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         mr = (sel < 6); mw = (sel >= 5);
         f3 = 3'($urandom_range(0, 7));
         a = $urandom; wd = $urandom; rd = $urandom;
         if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
         dly = $urandom_range(0, 2);
         model(mr, mw, f3, a, wd, rd, ok, exp_be, exp_wd, exp_rd);
         do_access(mr, mw, f3, a, wd, rd, dly);
         if (ok) begin
            tests_run++; if (o_fault1 !== 1'b0 || o_done_seen !== 1'b1 || o_occ !== 3 + dly || o_stall_cnt !== 2 + dly) begin tests_failed++; $display("FAIL rand_%0d_timing: fault=%b done=%b occ=%0d stall=%0d expected 0/1/%0d/%0d", i, o_fault1, o_done_seen, o_occ, o_stall_cnt, 3 + dly, 2 + dly); end
            tests_run++; if (o_addr !== (a / 4) * 4 || o_be !== exp_be || o_we !== mw) begin tests_failed++; $display("FAIL rand_%0d_bus: addr=%h be=%b we=%b expected %h/%b/%b", i, o_addr, o_be, o_we, (a / 4) * 4, exp_be, mw); end
            tests_run++; if (mw && o_wdata !== exp_wd) begin tests_failed++; $display("FAIL rand_%0d_wdata: got %h expected %h", i, o_wdata, exp_wd); end
            tests_run++; if (o_done_rd !== exp_rd || o_done_fault !== 1'b0 || o_unstable !== 1'b0 || o_stray_fault !== 1'b0) begin tests_failed++; $display("FAIL rand_%0d_result: rd=%h fault=%b unstable=%b stray=%b expected %h/0/0/0", i, o_done_rd, o_done_fault, o_unstable, o_stray_fault, exp_rd); end
         end else begin
            tests_run++; if ({o_fault1, o_stall1, o_req1} !== 3'b100 || o_rd1 !== 32'h0 || o_req_after !== 1'b0) begin tests_failed++; $display("FAIL rand_%0d_reject: fault/stall/req=%b rd=%h req_next=%b expected 100/0/0", i, {o_fault1, o_stall1, o_req1}, o_rd1, o_req_after); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw_basic();
      test_lb_lbu();
      test_sh();
      test_illegal();
      test_timeout();
      test_reset_mid_busy();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
